// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared ALU opcode, width and arbiter state definitions for alu_arb.
package alu_arb_pkg;

    localparam int DATA_WIDTH_ALU_OP = 4;
    localparam int DATA_WIDTH_GPR    = 32;

    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLTU = 4'd9;

    typedef enum logic {
        ALU_ARB_IDLE = 1'b0,
        ALU_ARB_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU shared by the alu_arb requesters.
module alu
    import alu_arb_pkg::*;
#(
    parameter int OP_W = DATA_WIDTH_ALU_OP,
    parameter int DW   = DATA_WIDTH_GPR
) (
    input  logic [OP_W-1:0] op,
    input  logic [DW-1:0]   in_0,
    input  logic [DW-1:0]   in_1,
    output logic [DW-1:0]   out
);

    localparam int SHW = $clog2(DW);

    logic [SHW-1:0] shamt;

    assign shamt = in_1[SHW-1:0];

    always_comb begin
        out = '0;
        case (op)
            ALU_OP_ADD:  out = in_0 + in_1;
            ALU_OP_SUB:  out = in_0 - in_1;
            ALU_OP_AND:  out = in_0 & in_1;
            ALU_OP_OR:   out = in_0 | in_1;
            ALU_OP_XOR:  out = in_0 ^ in_1;
            ALU_OP_SLL:  out = in_0 << shamt;
            ALU_OP_SRL:  out = in_0 >> shamt;
            ALU_OP_SRA:  out = $unsigned($signed(in_0) >>> shamt);
            ALU_OP_SLT:  out = {{(DW-1){1'b0}}, $signed(in_0) < $signed(in_1)};
            ALU_OP_SLTU: out = {{(DW-1){1'b0}}, in_0 < in_1};
            default:     out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-port valid/ready arbiter in front of one shared ALU with a registered result.
// ALU_ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int OP_W = DATA_WIDTH_ALU_OP,
    parameter int DW   = DATA_WIDTH_GPR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [DW-1:0]   req0_in_0,
    input  logic [DW-1:0]   req0_in_1,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [DW-1:0]   req1_in_0,
    input  logic [DW-1:0]   req1_in_1,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [DW-1:0]   resp0_data,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [DW-1:0]   resp1_data,
    output logic            busy
);

    arb_state_t      state;
    arb_state_t      next_state;
    logic            owner;
    logic            last_gnt;
    logic            grant;
    logic            owner_ready;
    logic            slot_free;
    logic            accept;
    logic [DW-1:0]   resp_data;
    logic [OP_W-1:0] alu_op;
    logic [DW-1:0]   alu_in_0;
    logic [DW-1:0]   alu_in_1;
    logic [DW-1:0]   alu_out;

    // A full slot frees up in the same cycle its owner takes the result.
    assign owner_ready = owner ? resp1_ready : resp0_ready;
    assign slot_free   = (state == ALU_ARB_IDLE) || owner_ready;
    assign grant       = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
    assign accept      = slot_free && (req0_valid || req1_valid);

    assign alu_op   = grant ? req1_op   : req0_op;
    assign alu_in_0 = grant ? req1_in_0 : req0_in_0;
    assign alu_in_1 = grant ? req1_in_1 : req0_in_1;

    alu #(
        .OP_W (OP_W),
        .DW   (DW)
    ) u_alu (
        .op   (alu_op),
        .in_0 (alu_in_0),
        .in_1 (alu_in_1),
        .out  (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ALU_ARB_IDLE;
            owner     <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                owner     <= grant;
                resp_data <= alu_out;
            end
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_gnt = 1'b1;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= grant;
        end
    end
`endif

    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = ALU_ARB_RESP;
        end else if ((state == ALU_ARB_RESP) && owner_ready) begin
            next_state = ALU_ARB_IDLE;
        end
    end

    always_comb begin
        busy        = (state == ALU_ARB_RESP);
        resp0_valid = (state == ALU_ARB_RESP) && !owner;
        resp1_valid = (state == ALU_ARB_RESP) && owner;
        resp0_data  = resp_data;
        resp1_data  = resp_data;
        req0_ready  = slot_free && req0_valid && !grant;
        req1_ready  = slot_free && req1_valid && grant;
    end

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - self-checking bench for alu_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_alu_arb;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_in_0, req0_in_1, req1_in_0, req1_in_1;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [31:0] resp0_data, resp1_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit fixed_prio;

    always #5 clk = ~clk;

    alu_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_in_0(req0_in_0), .req0_in_1(req0_in_1),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_in_0(req1_in_0), .req1_in_1(req1_in_1),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .busy(busy)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_AND:  return a & b;
            ALU_OP_OR:   return a | b;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SLL:  return a << sh;
            ALU_OP_SRL:  return a >> sh;
            ALU_OP_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:     return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = ALU_OP_ADD; req1_op = ALU_OP_ADD;
        req0_in_0 = 0; req0_in_1 = 0; req1_in_0 = 0; req1_in_1 = 0;
        resp0_ready = 1; resp1_ready = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        checks++;
        if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_valid: got %b exp 000", {resp0_valid, resp1_valid, busy});
        end
        checks++;
        if (resp0_data !== 32'd0 || resp1_data !== 32'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h exp 0", resp0_data, resp1_data);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1; req0_op = ALU_OP_ADD; req0_in_0 = 22; req0_in_1 = 33;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b exp 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0;
        checks++;
        if (resp0_valid !== 1 || resp0_data !== 32'd55 || resp1_valid !== 0) begin
            errors++; $display("FAIL single_resp: got v0=%b d=%0d v1=%b exp 1 55 0", resp0_valid, resp0_data, resp1_valid);
        end
        tick();
        checks++;
        if (busy !== 0 || resp0_valid !== 0) begin
            errors++; $display("FAIL single_idle: got busy=%b v0=%b exp 0 0", busy, resp0_valid);
        end
    endtask

    task automatic test_tie();
        logic        exp_g1;
        logic [31:0] exp_d1;
        do_reset();
        req0_valid = 1; req0_op = ALU_OP_SUB; req0_in_0 = 33; req0_in_1 = 22;
        req1_valid = 1; req1_op = ALU_OP_XOR; req1_in_0 = 32'h5E2E0AD6; req1_in_1 = 32'h5E2EF509;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL tie_grant0: got %b exp 10", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if (resp0_valid !== 1 || resp0_data !== 32'd11) begin
            errors++; $display("FAIL tie_resp0: got v=%b d=%0d exp 1 11", resp0_valid, resp0_data);
        end
        exp_g1 = fixed_prio ? 1'b0 : 1'b1;
        exp_d1 = fixed_prio ? 32'd11 : 32'h0000FFDF;
        @(negedge clk);
        checks++;
        if (req1_ready !== exp_g1 || req0_ready !== ~exp_g1) begin
            errors++; $display("FAIL tie_grant1: got %b%b exp %b%b", req0_ready, req1_ready, ~exp_g1, exp_g1);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        checks++;
        if (resp1_valid !== exp_g1 || resp0_valid !== ~exp_g1 || resp0_data !== exp_d1) begin
            errors++; $display("FAIL tie_resp1: got v0=%b v1=%b d=%h exp d=%h", resp0_valid, resp1_valid, resp0_data, exp_d1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_valid = 1; req1_op = ALU_OP_SLL; req1_in_0 = 32'h5E2E0AD6; req1_in_1 = 6;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1) begin
            errors++; $display("FAIL bp_accept1: got %b exp 1", req1_ready);
        end
        tick();
        req1_valid = 0; resp1_ready = 0;
        req0_valid = 1; req0_op = ALU_OP_ADD; req0_in_0 = 1; req0_in_1 = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 0 || resp1_valid !== 1 || resp1_data !== 32'h8B82B580) begin
                errors++; $display("FAIL bp_hold[%0d]: got r0=%b v1=%b d=%h exp 0 1 8b82b580", i, req0_ready, resp1_valid, resp1_data);
            end
            tick();
        end
        resp1_ready = 1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1) begin
            errors++; $display("FAIL bp_resume: got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        checks++;
        if (resp0_valid !== 1 || resp1_valid !== 0 || resp0_data !== 32'd3) begin
            errors++; $display("FAIL bp_next: got v0=%b v1=%b d=%0d exp 1 0 3", resp0_valid, resp1_valid, resp0_data);
        end
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            req0_valid = 1; req0_op = ALU_OP_ADD; req0_in_0 = k; req0_in_1 = k;
            @(negedge clk);
            checks++;
            if (req0_ready !== 1) begin
                errors++; $display("FAIL stream_ready[%0d]: got %b exp 1", k, req0_ready);
            end
            tick();
            checks++;
            if (resp0_valid !== 1 || resp0_data !== 32'(2 * k)) begin
                errors++; $display("FAIL stream_data[%0d]: got v=%b d=%0d exp 1 %0d", k, resp0_valid, resp0_data, 2 * k);
            end
        end
        req0_valid = 0;
        tick();
        checks++;
        if (busy !== 0) begin
            errors++; $display("FAIL stream_idle: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req0_valid = 1; req0_op = ALU_OP_SLT; req0_in_0 = 32'hFFFFFFFB; req0_in_1 = 3;
        tick();
        req0_valid = 0; resp0_ready = 0;
        checks++;
        if (resp0_valid !== 1 || resp0_data !== 32'd1) begin
            errors++; $display("FAIL rst_mid_pre: got v=%b d=%0d exp 1 1", resp0_valid, resp0_data);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_drop: got %b exp 000", {resp0_valid, resp1_valid, busy});
        end
        @(posedge clk);
        #1 rst_n = 1;
        resp0_ready = 1;
        req0_valid = 1; req1_valid = 1; req1_op = ALU_OP_OR;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_tie: got %b exp 10", {req0_ready, req1_ready});
        end
        tick();
        clear_inputs();
        tick();
    endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req0_op = ALU_OP_ADD; req0_in_0 = i; req0_in_1 = 10;
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== 2'b10) begin
                errors++; $display("FAIL fixed_grant[%0d]: got %b exp 10", i, {req0_ready, req1_ready});
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask
`endif

    task automatic test_random();
        bit          m_full, m_owner, m_last;
        logic [31:0] m_data;
        bit          acc0, acc1, g, sf, both;
        do_reset();
        m_full = 0; m_owner = 0; m_last = 1; m_data = 0;
        acc0 = 1; acc1 = 1;
        for (int c = 0; c < 300; c++) begin
            if (!(req0_valid && !acc0)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op = 4'($urandom_range(0, 9)); req0_in_0 = $urandom; req0_in_1 = $urandom;
            end
            if (!(req1_valid && !acc1)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op = 4'($urandom_range(0, 9)); req1_in_0 = $urandom; req1_in_1 = $urandom;
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            sf   = !m_full || (m_owner ? resp1_ready : resp0_ready);
            both = req0_valid && req1_valid;
            g    = both ? (fixed_prio ? 1'b0 : !m_last) : req1_valid;
            acc0 = sf && req0_valid && !g;
            acc1 = sf && req1_valid && g;
            @(negedge clk);
            checks++;
            if (req0_ready !== acc0 || req1_ready !== acc1) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b%b exp %b%b", c, req0_ready, req1_ready, acc0, acc1);
            end
            if (acc0 || acc1) begin
                m_full = 1; m_owner = acc1; m_last = acc1;
                m_data = acc1 ? ref_alu(req1_op, req1_in_0, req1_in_1) : ref_alu(req0_op, req0_in_0, req0_in_1);
            end else if (sf) begin
                m_full = 0;
            end
            tick();
            checks++;
            if (resp0_valid !== (m_full && !m_owner) || resp1_valid !== (m_full && m_owner) || busy !== m_full) begin
                errors++; $display("FAIL rand_valid[%0d]: got v0=%b v1=%b busy=%b exp full=%b owner=%b", c, resp0_valid, resp1_valid, busy, m_full, m_owner);
            end
            if (m_full) begin
                checks++;
                if (resp0_data !== m_data || resp1_data !== m_data) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h/%h exp %h", c, resp0_data, resp1_data, m_data);
                end
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        fixed_prio = 1;
`else
        fixed_prio = 0;
`endif
        test_reset();
        test_single_op();
        test_tie();
        test_backpressure();
        test_streaming();
        test_reset_mid_op();
`ifdef ALU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
